// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes,
// FSM state encoding and the access-size decode.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Access size in bytes (1, 2, 4 or 8) from the low two funct3 bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] size;
        case (funct3[1:0])
            2'b00:   size = 4'd1;
            2'b01:   size = 4'd2;
            2'b10:   size = 4'd4;
            default: size = 4'd8;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_load_align.sv
// Load extension: takes the 8 bytes starting at the (already aligned)
// access address and sign- or zero-extends the selected width.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    // Width select and extension; the illegal code yields zero.
    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{56{raw[7]}},  raw[7:0]};
            F3_H:    data = {{48{raw[15]}}, raw[15:0]};
            F3_W:    data = {{32{raw[31]}}, raw[31:0]};
            F3_D:    data = raw;
            F3_BU:   data = {56'd0, raw[7:0]};
            F3_HU:   data = {48'd0, raw[15:0]};
            F3_WU:   data = {32'd0, raw[31:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// latency, performs the access on a little-endian byte array split into
// eight byte lanes, and holds the response until the consumer takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int LANE_DEPTH = DEPTH_BYTES / 8;
    localparam int IW         = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
    localparam int CW         = $clog2(LATENCY + 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            req_ready_reg;

    logic            write_reg;
    logic [63:0]     addr_reg;
    logic [63:0]     wdata_reg;
    logic [2:0]      funct3_reg;

    logic            err_reg;
    logic            load_ok_reg;

    logic            accept;
    logic            access;
    logic            store_en;
    logic            load_en;

    logic            cur_write;
    logic [63:0]     cur_addr;
    logic [63:0]     cur_wdata;
    logic [2:0]      cur_funct3;
    logic [3:0]      cur_size;
    logic [64:0]     cur_end;
    logic            cur_misaligned;
    logic            cur_illegal;
    logic            cur_range_err;
    logic            cur_err;
    logic [IW-1:0]   cur_idx;

    logic [63:0]     wshift;
    logic [63:0]     lane_word;
    logic [63:0]     load_raw;
    logic [63:0]     load_data;

    assign accept = bus.req_valid && req_ready_reg;

    // The access happens on the edge that enters RESP. With a one-cycle
    // latency that is the accept edge itself, so the live request is used.
    assign access = rst && (((LATENCY == 1) && (state_reg == ST_IDLE) && accept) ||
                            ((state_reg == ST_WAIT) && (cnt_reg == CW'(1))));

    assign cur_write  = (state_reg == ST_IDLE) ? bus.req_write  : write_reg;
    assign cur_addr   = (state_reg == ST_IDLE) ? bus.req_addr   : addr_reg;
    assign cur_wdata  = (state_reg == ST_IDLE) ? bus.req_wdata  : wdata_reg;
    assign cur_funct3 = (state_reg == ST_IDLE) ? bus.req_funct3 : funct3_reg;

    assign cur_size = size_bytes(cur_funct3);
    // 65-bit sum so that addresses near 2^64 cannot wrap into range.
    assign cur_end  = {1'b0, cur_addr} + {61'd0, cur_size};

    // Error classification of the request about to be performed.
    always_comb begin
        cur_misaligned = 1'b0;
        case (cur_funct3[1:0])
            2'b00:   cur_misaligned = 1'b0;
            2'b01:   cur_misaligned = cur_addr[0];
            2'b10:   cur_misaligned = |cur_addr[1:0];
            default: cur_misaligned = |cur_addr[2:0];
        endcase
        cur_illegal   = cur_write ? cur_funct3[2] : (cur_funct3 == 3'b111);
        cur_range_err = cur_end > 65'(DEPTH_BYTES);
        cur_err       = cur_misaligned || cur_illegal || cur_range_err;
    end

    assign store_en = access && cur_write && !cur_err;
    assign load_en  = access && !cur_write && !cur_err;

    assign cur_idx = cur_addr[IW+2:3];
    assign wshift  = cur_wdata << {cur_addr[2:0], 3'b000};

    // Next-state and latency counter.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = ST_RESP;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CW'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == CW'(1)) begin
                    state_next = ST_RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and registered ready (low throughout reset).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            req_ready_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_ready_reg <= (state_next == ST_IDLE);
        end
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_reg  <= bus.req_write;
            addr_reg   <= bus.req_addr;
            wdata_reg  <= bus.req_wdata;
            funct3_reg <= bus.req_funct3;
        end
    end

    // Response status, set at the access edge and cleared once consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_reg     <= 1'b0;
            load_ok_reg <= 1'b0;
        end else if (access) begin
            err_reg     <= cur_err;
            load_ok_reg <= !cur_err && !cur_write;
        end else if ((state_reg == ST_RESP) && bus.resp_ready) begin
            err_reg     <= 1'b0;
            load_ok_reg <= 1'b0;
        end
    end

    // One byte-wide RAM per lane; a naturally aligned access never spans
    // two doublewords, so every lane shares the same row index.
    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_lane
        logic [7:0] mem [LANE_DEPTH];
        logic [7:0] rd_q;
        logic       be;

        assign be = (4'(gi) >= {1'b0, cur_addr[2:0]}) &&
                    (4'(gi) <  ({1'b0, cur_addr[2:0]} + cur_size));

        // Byte-enabled write and registered read of this lane.
        always_ff @(posedge clk) begin
            if (store_en && be) begin
                mem[cur_idx] <= wshift[gi*8 +: 8];
            end
            if (load_en) begin
                rd_q <= mem[cur_idx];
            end
        end

        assign lane_word[gi*8 +: 8] = rd_q;
    end

    assign load_raw = lane_word >> {addr_reg[2:0], 3'b000};

    dmem_load_align u_align (
        .raw    (load_raw),
        .funct3 (funct3_reg),
        .data   (load_data)
    );

    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = (state_reg == ST_RESP);
    assign bus.resp_err   = err_reg;
    assign bus.resp_rdata = load_ok_reg ? load_data : 64'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written
// back-pressure and reset sequences, then randomized traffic checked
// against a byte-array reference model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus_if ();

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [DEPTH];

    typedef struct packed {
        logic        w;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  f3;
        logic [63:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic w, input logic [63:0] a, input logic [63:0] wd,
                                    input logic [2:0] f3, input logic [63:0] rd, input logic er);
        vec_t v;
        v.w = w; v.addr = a; v.wdata = wd; v.f3 = f3; v.exp_rd = rd; v.exp_er = er;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: byte-array semantics straight from the load/store rules.
    task automatic ref_txn(input logic w, input logic [63:0] a, input logic [63:0] wd,
                           input logic [2:0] f3, output logic [63:0] rd, output logic er);
        int size;
        logic [63:0] v;
        size = 1 << f3[1:0];
        er = (w && f3[2]) || (!w && f3 == 3'b111) ||
             ((a % 64'(size)) != 64'd0) || (a > 64'(DEPTH - size));
        rd = '0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8*i));
                if (!f3[2] && size < 8 && v[8*size-1]) v = v - (64'd1 << (8*size));
                rd = v;
            end
        end
    endtask

    // Drive one request (called at a falling edge), return the response and
    // the number of edges from the accept edge to the first resp_valid edge.
    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] wd,
                          input logic [2:0] f3, output logic [63:0] rd, output logic er,
                          output int lat);
        int guard;
        rd = '0; er = 1'b0; lat = 0;
        bus_if.req_write  = w;
        bus_if.req_addr   = a;
        bus_if.req_wdata  = wd;
        bus_if.req_funct3 = f3;
        bus_if.resp_ready = 1'b1;
        bus_if.req_valid  = 1'b1;
        guard = 0;
        while (bus_if.req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (bus_if.req_ready !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: req_ready=%b required=1", bus_if.req_ready);
            bus_if.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus_if.resp_valid !== 1'b1 && lat < 20);
        rd = bus_if.resp_rdata;
        er = bus_if.resp_err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_txn(input string name, input logic w, input logic [63:0] a,
                           input logic [63:0] wd, input logic [2:0] f3, input logic use_tab,
                           input logic [63:0] tab_rd, input logic tab_er);
        logic [63:0] mrd, rd;
        logic mer, er;
        int lat;
        ref_txn(w, a, wd, f3, mrd, mer);
        do_req(w, a, wd, f3, rd, er, lat);
        check({name, "_rdata"}, rd, use_tab ? tab_rd : mrd);
        check({name, "_err"}, 64'(er), 64'(use_tab ? tab_er : mer));
        check({name, "_lat"}, 64'(lat), 64'(LAT));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hold_exp, dummy_rd, a;
        logic        dummy_er, w;
        logic [2:0]  f3;
        int          guard, sel, size;

        bus_if.req_valid  = 1'b0;
        bus_if.req_write  = 1'b0;
        bus_if.req_addr   = '0;
        bus_if.req_wdata  = '0;
        bus_if.req_funct3 = '0;
        bus_if.resp_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus_if.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus_if.resp_valid), 64'd0);
        check("rst_resp_rdata", bus_if.resp_rdata, 64'd0);
        check("rst_resp_err", 64'(bus_if.resp_err), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_ready", 64'(bus_if.req_ready), 64'd1);

        // Directed vectors.
        add_vec(1, 64'h10, 64'h8877665544332211, F3_D, 64'h0, 0);
        add_vec(0, 64'h10, 64'h0, F3_D,  64'h8877665544332211, 0);
        add_vec(0, 64'h17, 64'h0, F3_B,  64'hFFFFFFFFFFFFFF88, 0);
        add_vec(0, 64'h17, 64'h0, F3_BU, 64'h88, 0);
        add_vec(0, 64'h16, 64'h0, F3_H,  64'hFFFFFFFFFFFF8877, 0);
        add_vec(0, 64'h16, 64'h0, F3_HU, 64'h8877, 0);
        add_vec(0, 64'h14, 64'h0, F3_WU, 64'h88776655, 0);
        add_vec(0, 64'h10, 64'h0, F3_W,  64'h44332211, 0);
        add_vec(1, 64'h10, 64'hFFFFFFFFFFFFAAAA, F3_H, 64'h0, 0);
        add_vec(0, 64'h10, 64'h0, F3_D,  64'h887766554433AAAA, 0);
        add_vec(0, 64'h12, 64'h0, F3_D,  64'h0, 1);
        add_vec(0, 64'h10, 64'h0, F3_D,  64'h887766554433AAAA, 0);
        add_vec(1, 64'(DEPTH - 2), 64'h12345678, F3_W, 64'h0, 1);
        add_vec(1, 64'h10, 64'h55, 3'b100, 64'h0, 1);
        add_vec(1, 64'h10, 64'h55, 3'b111, 64'h0, 1);
        add_vec(0, 64'h10, 64'h0, 3'b111,  64'h0, 1);
        add_vec(0, 64'h10, 64'h0, F3_D,  64'h887766554433AAAA, 0);
        add_vec(0, 64'h0001000000000010, 64'h0, F3_D, 64'h0, 1);
        add_vec(0, 64'h8000000000000010, 64'h0, F3_D, 64'h0, 1);
        add_vec(0, 64'hFFFFFFFFFFFFFFF8, 64'h0, F3_D, 64'h0, 1);
        add_vec(1, 64'(DEPTH - 8), 64'h0123456789ABCDEF, F3_D, 64'h0, 0);
        add_vec(0, 64'(DEPTH - 8), 64'h0, F3_D, 64'h0123456789ABCDEF, 0);
        add_vec(0, 64'(DEPTH - 4), 64'h0, F3_D, 64'h0, 1);
        add_vec(0, 64'(DEPTH - 4), 64'h0, F3_W, 64'h01234567, 0);
        add_vec(0, 64'(DEPTH - 1), 64'h0, F3_B, 64'h01, 0);
        add_vec(0, 64'(DEPTH),     64'h0, F3_B, 64'h0, 1);
        add_vec(1, 64'(DEPTH),     64'h1, F3_W, 64'h0, 1);
        add_vec(1, 64'h11, 64'hFFFFFFFFFFFFFF5A, F3_B, 64'h0, 0);
        add_vec(0, 64'h10, 64'h0, F3_D,  64'h8877665544335AAA, 0);
        add_vec(1, 64'h20, 64'h1111, F3_D, 64'h0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].wdata,
                    vecs[i].f3, 1'b1, vecs[i].exp_rd, vecs[i].exp_er);
        end

        // Back-pressure: response held for 5 cycles with resp_ready low.
        ref_txn(1'b0, 64'h10, 64'h0, F3_D, hold_exp, dummy_er);
        bus_if.resp_ready = 1'b0;
        bus_if.req_write  = 1'b0;
        bus_if.req_addr   = 64'h10;
        bus_if.req_funct3 = F3_D;
        bus_if.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bus_if.resp_valid !== 1'b1 && guard < 20);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_valid", i), 64'(bus_if.resp_valid), 64'd1);
            check($sformatf("hold%0d_rdata", i), bus_if.resp_rdata, hold_exp);
            check($sformatf("hold%0d_err", i), 64'(bus_if.resp_err), 64'd0);
            check($sformatf("hold%0d_ready", i), 64'(bus_if.req_ready), 64'd0);
            @(negedge clk);
        end
        bus_if.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_release_ready", 64'(bus_if.req_ready), 64'd1);
        check("hold_release_valid", 64'(bus_if.resp_valid), 64'd0);

        // Reset while a store waits: the store must be dropped.
        bus_if.req_write  = 1'b1;
        bus_if.req_addr   = 64'h20;
        bus_if.req_wdata  = 64'hDEAD;
        bus_if.req_funct3 = F3_D;
        bus_if.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("wait_rst_valid", 64'(bus_if.resp_valid), 64'd0);
        check("wait_rst_ready", 64'(bus_if.req_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("wait_rst_idle_ready", 64'(bus_if.req_ready), 64'd1);
        run_txn("after_wait_rst_ld20", 1'b0, 64'h20, 64'h0, F3_D, 1'b0, 64'h0, 1'b0);

        // Reset while a committed store sits in RESP: the store must remain.
        ref_txn(1'b1, 64'h28, 64'hBEEF, F3_D, dummy_rd, dummy_er);
        bus_if.resp_ready = 1'b0;
        bus_if.req_write  = 1'b1;
        bus_if.req_addr   = 64'h28;
        bus_if.req_wdata  = 64'hBEEF;
        bus_if.req_funct3 = F3_D;
        bus_if.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (bus_if.resp_valid !== 1'b1 && guard < 20);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("resp_rst_valid", 64'(bus_if.resp_valid), 64'd0);
        rst = 1'b1;
        bus_if.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run_txn("after_resp_rst_ld28", 1'b0, 64'h28, 64'h0, F3_D, 1'b0, 64'h0, 1'b0);

        // Fill the whole array so random loads never see unwritten bytes.
        for (int i = 0; i < DEPTH / 8; i++) begin
            run_txn("fill", 1'b1, 64'(i * 8), {$urandom, $urandom}, F3_D, 1'b0, 64'h0, 1'b0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            sel  = $urandom_range(0, 9);
            f3   = 3'($urandom_range(0, 7));
            w    = 1'($urandom_range(0, 1));
            size = 1 << f3[1:0];
            if (sel < 7)       a = 64'($urandom_range(0, DEPTH - 1)) & ~64'(size - 1);
            else if (sel == 7) a = 64'($urandom_range(0, DEPTH - 1));
            else if (sel == 8) a = 64'(DEPTH - 16 + $urandom_range(0, 16));
            else               a = {32'($urandom), 32'($urandom)};
            run_txn($sformatf("rnd%0d", i), w, a, {$urandom, $urandom}, f3, 1'b0, 64'h0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
